// File: rtl/fifo_rr_push_arbiter.sv
// fifo_rr_push_arbiter: round-robin, burst-bounded sharing of one fifo write port among NUM_REQ producers
//   clk, rst (async, active-high)
//   req_valid/req_data/req_ready : per-producer valid/ready word interface, word i at [i*DATA_SIZE +: DATA_SIZE]
//   fifo_full/fifo_push/fifo_data : fifo write port, never pushes while full
//   grant_id/busy/stall_cnt       : current grant, GRANT-state flag, saturating full-stall cycle count
module fifo_rr_push_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_push,
    output logic [DATA_SIZE-1:0]         fifo_data,
    output logic [GW-1:0]                grant_id,
    output logic                         busy,
    output logic [15:0]                  stall_cnt
);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t         state, state_n;
    logic [GW-1:0]  rr_ptr, rr_n, grant_n, pick;
    logic [BW-1:0]  beat_cnt, beat_n;
    logic [15:0]    stall_n;
    logic           gv, accept, last;
    assign busy      = state == GRANT;
    assign gv        = req_valid[grant_id];
    assign accept    = busy & gv & ~fifo_full;
    assign last      = beat_cnt == BW'(BURST_LEN - 1);
    assign fifo_push = accept;
    assign fifo_data = busy ? req_data[grant_id*DATA_SIZE +: DATA_SIZE] : '0;
    assign req_ready = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id : '0;
    // Walk offsets from far to near so the nearest valid index after rr_ptr wins.
    always_comb begin
        int j;
        j    = 0;
        pick = grant_id;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            j = j >= NUM_REQ ? j - NUM_REQ : j;
            if (req_valid[j]) pick = GW'(j);
        end
    end
    always_comb begin
        state_n = state;
        grant_n = grant_id;
        rr_n    = rr_ptr;
        beat_n  = beat_cnt;
        stall_n = stall_cnt;
        if (!busy) begin
            if (|req_valid) begin
                state_n = GRANT;
                grant_n = pick;
                beat_n  = '0;
            end
        end else if ((accept && last) || !gv) begin
            state_n = IDLE;
            rr_n    = grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            beat_n  = '0;
        end else if (accept) begin
            beat_n = beat_cnt + 1'b1;
        end else begin
            stall_n = stall_cnt == 16'hFFFF ? stall_cnt : stall_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            grant_id  <= grant_n;
            rr_ptr    <= rr_n;
            beat_cnt  <= beat_n;
            stall_cnt <= stall_n;
        end
    end
endmodule
